// File: rtl/quad_pkg.sv
//------------------------------------------------------------------------------
// quad_pkg
//   Shared types, constants and the direction-decode helper for the quadrature
//   step decoder and its glitch filter.
//   Contents:
//     quad_state_e  : decoder FSM states (INIT, TRACK)
//     quad_phase_t  : synchronised {A,B} phase pair
//     quad_dir_t    : {valid, illegal, up} decode result
//     QUAD_UP/DOWN  : up_down encodings
//     quad_dir()    : classifies a prev->cur phase transition
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package quad_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    TRACK = 1'b1
  } quad_state_e;

  typedef logic [1:0] quad_phase_t;

  typedef struct packed {
    logic valid;    // single legal step
    logic illegal;  // both phases changed at once
    logic up;       // direction of a valid step
  } quad_dir_t;

  localparam logic QUAD_UP   = 1'b1;
  localparam logic QUAD_DOWN = 1'b0;

  // Gray position 00,01,11,10 maps to 0,1,2,3 so a step is a +/-1 difference.
  function automatic logic [1:0] quad_gray2bin(input quad_phase_t g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  function automatic quad_dir_t quad_dir(input quad_phase_t prev, input quad_phase_t cur);
    logic [1:0] d;
    quad_dir_t  r;
    d         = quad_gray2bin(cur) - quad_gray2bin(prev);
    r.valid   = (d == 2'd1) || (d == 2'd3);
    r.illegal = (d == 2'd2);
    r.up      = (d == 2'd1);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_step_decoder_if.sv
//------------------------------------------------------------------------------
// quad_step_decoder_if
//   Groups the encoder inputs, control strobes and step-protocol outputs of
//   quad_step_decoder.
//   Signals:
//     quad_a, quad_b : encoder phases (asynchronous to clk)
//     en             : decode enable
//     err_clr        : clears sticky err
//     step           : one-cycle pulse per accepted transition
//     up_down        : direction of last step (1 = up)
//     position       : wrap-around position count, WIDTH bits
//     err            : sticky illegal-transition flag
//   Modports: master (stimulus/consumer side), slave (decoder side).
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface quad_step_decoder_if #(
  parameter int WIDTH = 4
) ();

  logic             quad_a;
  logic             quad_b;
  logic             en;
  logic             err_clr;
  logic             step;
  logic             up_down;
  logic [WIDTH-1:0] position;
  logic             err;

  modport master (
    output quad_a, quad_b, en, err_clr,
    input  step, up_down, position, err
  );

  modport slave (
    input  quad_a, quad_b, en, err_clr,
    output step, up_down, position, err
  );

endinterface

`default_nettype wire

// File: rtl/quad_glitch_filter.sv
//------------------------------------------------------------------------------
// quad_glitch_filter
//   Per-phase stability filter. The filtered output follows the raw input only
//   after the raw value has differed from it for FILTER_LEN consecutive cycles;
//   any bounce back restarts the count.
//   Ports:
//     clk    : rising-edge clock
//     rstn   : asynchronous active-high reset (filtered value resets to 0)
//     i_raw  : synchronised phase input
//     o_filt : filtered phase output
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module quad_glitch_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_raw,
  output logic o_filt
);

  localparam int c_cnt_w = $clog2(FILTER_LEN + 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_filt;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (i_raw == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt == c_cnt_w'(FILTER_LEN - 1)) begin
      // This cycle is the FILTER_LEN-th consecutive differing sample.
      r_filt <= i_raw;
      r_cnt  <= '0;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_filt = r_filt;

endmodule

`default_nettype wire

// File: rtl/quad_step_decoder.sv
//------------------------------------------------------------------------------
// quad_step_decoder
//   Synchronises a quadrature A/B pair, decodes direction into a one-cycle
//   step pulse plus up_down, keeps a wrap-around position count and flags
//   illegal (double-bit) transitions in a sticky err.
//   Optional glitch filter: compile with QUAD_GLITCH_FILTER_EN defined.
//   Ports:
//     clk  : rising-edge clock
//     rstn : asynchronous active-high reset
//     bus  : quad_step_decoder_if.slave (quad_a, quad_b, en, err_clr in;
//            step, up_down, position, err out)
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic               clk,
  input  logic               rstn,
  quad_step_decoder_if.slave bus
);

`ifdef QUAD_GLITCH_FILTER_EN
  localparam int c_filt_delay = FILTER_LEN;
`else
  // No filter stage in this build, so it adds no pipeline delay.
  localparam int c_filt_delay = 0 * FILTER_LEN;
`endif

  // The synchronisers (and filter) reset to 0, so the decoder input only
  // reflects the real pins once the pipeline has refilled. INIT keeps loading
  // prev until then, so a non-zero pin state at release is never mistaken
  // for a step or an illegal jump.
  localparam int c_warmup = SYNC_STAGES + 1 + c_filt_delay;
  localparam int c_init_w = $clog2(c_warmup + 1);

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  quad_phase_t            w_sync;
  quad_phase_t            w_cur;

  quad_state_e            r_state;
  quad_state_e            w_state_nxt;
  logic [c_init_w-1:0]    r_init_cnt;

  quad_phase_t            r_prev;
  quad_dir_t              w_dir;
  logic                   r_step,     w_step_nxt;
  logic                   r_up_down,  w_up_down_nxt;
  logic [WIDTH-1:0]       r_position, w_pos_nxt;
  logic                   r_err,      w_err_nxt;

  // Input synchronisers
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], bus.quad_a};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], bus.quad_b};
    end
  end

  assign w_sync = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

`ifdef QUAD_GLITCH_FILTER_EN
  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk    (clk),
    .rstn   (rstn),
    .i_raw  (w_sync[1]),
    .o_filt (w_cur[1])
  );

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk    (clk),
    .rstn   (rstn),
    .i_raw  (w_sync[0]),
    .o_filt (w_cur[0])
  );
`else
  assign w_cur = w_sync;
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (r_init_cnt == c_init_w'(c_warmup - 1)) w_state_nxt = TRACK;
      TRACK:   w_state_nxt = TRACK;
      default: w_state_nxt = INIT;
    endcase
  end

  // FSM: outputs (next values of the registered outputs)
  always_comb begin
    w_dir         = quad_dir(r_prev, w_cur);
    w_step_nxt    = 1'b0;
    w_up_down_nxt = r_up_down;
    w_pos_nxt     = r_position;
    w_err_nxt     = bus.err_clr ? 1'b0 : r_err;
    if ((r_state == TRACK) && bus.en) begin
      if (w_dir.valid) begin
        w_step_nxt    = 1'b1;
        w_up_down_nxt = w_dir.up ? QUAD_UP : QUAD_DOWN;
        w_pos_nxt     = w_dir.up ? (r_position + 1'b1) : (r_position - 1'b1);
      end
      // Set dominates a simultaneous err_clr.
      if (w_dir.illegal) begin
        w_err_nxt = 1'b1;
      end
    end
  end

  // prev tracks the input every cycle, in both states and regardless of en.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_prev     <= '0;
      r_step     <= 1'b0;
      r_up_down  <= 1'b0;
      r_position <= '0;
      r_err      <= 1'b0;
    end else begin
      r_prev     <= w_cur;
      r_step     <= w_step_nxt;
      r_up_down  <= w_up_down_nxt;
      r_position <= w_pos_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign bus.step     = r_step;
  assign bus.up_down  = r_up_down;
  assign bus.position = r_position;
  assign bus.err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
//------------------------------------------------------------------------------
// tb_quad_step_decoder
//   Self-checking bench for quad_step_decoder. A scoreboard queue holds the
//   expected step pulses (cycle, direction, position) pushed as each phase
//   change is driven; a monitor pops and compares them as step pulses appear.
//   Glitch-filter scenario runs when QUAD_GLITCH_FILTER_EN is defined.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_quad_step_decoder;

  localparam int WIDTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 3;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam int LAT     = SYNC_STAGES + FILTER_LEN + 1;
  localparam int GAP_MIN = FILTER_LEN + 1;
`else
  localparam int LAT     = SYNC_STAGES + 1;
  localparam int GAP_MIN = 1;
`endif
  localparam int WARMUP = LAT + 4;

  typedef struct {
    int               cyc;
    logic             up;
    logic [WIDTH-1:0] pos;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  logic             clk  = 1'b0;
  logic             rstn = 1'b1;
  int               cyc    = 0;
  int               errors = 0;
  int               checks = 0;
  logic [1:0]       m_ab;
  logic [WIDTH-1:0] m_pos;

  quad_step_decoder_if #(.WIDTH(WIDTH)) u_bus ();

  quad_step_decoder #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rstn && (u_bus.step === 1'b1)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step: cycle %0d step=1 position=%0d, no step expected", cyc, u_bus.position);
      end else begin
        mon_e = sb_q.pop_front();
        if (cyc !== mon_e.cyc) begin
          errors++;
          $display("FAIL step_latency: step at cycle %0d, expected cycle %0d", cyc, mon_e.cyc);
        end
        checks++;
        if (u_bus.up_down !== mon_e.up) begin
          errors++;
          $display("FAIL step_dir: up_down=%0b, expected %0b", u_bus.up_down, mon_e.up);
        end
        checks++;
        if (u_bus.position !== mon_e.pos) begin
          errors++;
          $display("FAIL step_pos: position=%0d, expected %0d", u_bus.position, mon_e.pos);
        end
      end
    end
  end

  function automatic logic [1:0] up_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Drive a new A/B pair (called at a negedge) and queue the expected step.
  task automatic drive_ab(input logic [1:0] ab);
    if (u_bus.en === 1'b1) begin
      if (ab == up_next(m_ab)) begin
        m_pos = m_pos + 1'b1;
        sb_q.push_back('{cyc: cyc + LAT, up: 1'b1, pos: m_pos});
      end else if (m_ab == up_next(ab)) begin
        m_pos = m_pos - 1'b1;
        sb_q.push_back('{cyc: cyc + LAT, up: 1'b0, pos: m_pos});
      end
    end
    m_ab         = ab;
    u_bus.quad_a = ab[1];
    u_bus.quad_b = ab[0];
  endtask

  task automatic do_move(input logic [1:0] ab);
    drive_ab(ab);
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected steps never appeared, expected 0 pending", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 4;
    if (u_bus.step !== 1'b0)     begin errors++; $display("FAIL rst_step: %0b, expected 0", u_bus.step); end
    if (u_bus.up_down !== 1'b0)  begin errors++; $display("FAIL rst_up_down: %0b, expected 0", u_bus.up_down); end
    if (u_bus.position !== 4'd0) begin errors++; $display("FAIL rst_position: %0d, expected 0", u_bus.position); end
    if (u_bus.err !== 1'b0)      begin errors++; $display("FAIL rst_err: %0b, expected 0", u_bus.err); end
    rstn  = 1'b0;
    m_pos = '0;
    repeat (WARMUP) @(negedge clk);
    checks += 2;
    if (u_bus.position !== 4'd0) begin errors++; $display("FAIL init_position: %0d, expected 0", u_bus.position); end
    if (u_bus.err !== 1'b0)      begin errors++; $display("FAIL init_err: %0b, expected 0", u_bus.err); end
  endtask

  task automatic test_down_wrap;
    do_move(2'b01);                               // 11 -> 01 : down from 0
    checks += 2;
    if (u_bus.position !== 4'd15) begin errors++; $display("FAIL down_wrap_pos: %0d, expected 15", u_bus.position); end
    if (u_bus.up_down !== 1'b0)   begin errors++; $display("FAIL down_wrap_dir: %0b, expected 0", u_bus.up_down); end
    do_move(2'b00);                               // -> 14
    wait_drain("down_wrap");
  endtask

  task automatic test_up_steps;
    do_move(2'b01);
    do_move(2'b11);
    do_move(2'b10);
    do_move(2'b00);                               // 14 -> 15 -> 0 -> 1 -> 2
    wait_drain("up_steps");
    checks += 2;
    if (u_bus.position !== 4'd2) begin errors++; $display("FAIL up_pos: %0d, expected 2", u_bus.position); end
    if (u_bus.up_down !== 1'b1)  begin errors++; $display("FAIL up_dir: %0b, expected 1", u_bus.up_down); end
    do_move(2'b10);                               // 00 -> 10 : down to 1
    checks++;
    if (u_bus.position !== 4'd1) begin errors++; $display("FAIL down_pos: %0d, expected 1", u_bus.position); end
  endtask

  task automatic test_illegal;
    do_move(2'b01);                               // 10 -> 01 illegal
    checks += 2;
    if (u_bus.err !== 1'b1)      begin errors++; $display("FAIL illegal_err: %0b, expected 1", u_bus.err); end
    if (u_bus.position !== 4'd1) begin errors++; $display("FAIL illegal_pos: %0d, expected 1", u_bus.position); end
    u_bus.err_clr = 1'b1;
    @(negedge clk);
    u_bus.err_clr = 1'b0;
    checks++;
    if (u_bus.err !== 1'b0) begin errors++; $display("FAIL err_clr: err=%0b, expected 0", u_bus.err); end
    drive_ab(2'b10);                              // 01 -> 10 illegal, with err_clr at decode
    repeat (LAT - 1) @(negedge clk);
    u_bus.err_clr = 1'b1;
    @(negedge clk);
    u_bus.err_clr = 1'b0;
    checks += 2;
    if (u_bus.err !== 1'b1)      begin errors++; $display("FAIL set_wins: err=%0b, expected 1", u_bus.err); end
    if (u_bus.position !== 4'd1) begin errors++; $display("FAIL set_wins_pos: %0d, expected 1", u_bus.position); end
    u_bus.err_clr = 1'b1;
    @(negedge clk);
    u_bus.err_clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_enable;
    u_bus.en = 1'b0;
    do_move(2'b00);
    do_move(2'b01);                               // two up steps, gated
    checks += 2;
    if (u_bus.position !== 4'd1) begin errors++; $display("FAIL en_gate_pos: %0d, expected 1", u_bus.position); end
    if (u_bus.err !== 1'b0)      begin errors++; $display("FAIL en_gate_err: %0b, expected 0", u_bus.err); end
    u_bus.en = 1'b1;
    do_move(2'b11);                               // -> 2
    wait_drain("enable");
    checks += 2;
    if (u_bus.position !== 4'd2) begin errors++; $display("FAIL en_resume_pos: %0d, expected 2", u_bus.position); end
    if (u_bus.err !== 1'b0)      begin errors++; $display("FAIL en_resume_err: %0b, expected 0", u_bus.err); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] seq [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
    for (int i = 0; i < 4; i++) begin
      drive_ab(seq[i]);
      repeat (GAP_MIN) @(negedge clk);
    end
    wait_drain("back_to_back");
    repeat (2) @(negedge clk);
    checks += 2;
    if (u_bus.position !== 4'd6) begin errors++; $display("FAIL b2b_pos: %0d, expected 6", u_bus.position); end
    if (u_bus.err !== 1'b0)      begin errors++; $display("FAIL b2b_err: %0b, expected 0", u_bus.err); end
  endtask

`ifdef QUAD_GLITCH_FILTER_EN
  task automatic test_glitch;
    u_bus.quad_a = 1'b0;                          // 2-cycle bounce on A
    repeat (2) @(negedge clk);
    u_bus.quad_a = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    checks += 2;
    if (u_bus.position !== 4'd6) begin errors++; $display("FAIL glitch_pos: %0d, expected 6", u_bus.position); end
    if (u_bus.err !== 1'b0)      begin errors++; $display("FAIL glitch_err: %0b, expected 0", u_bus.err); end
    do_move(2'b01);                               // stable change: down to 5
    wait_drain("glitch");
    checks++;
    if (u_bus.position !== 4'd5) begin errors++; $display("FAIL filt_pos: %0d, expected 5", u_bus.position); end
  endtask
`endif

  task automatic test_reset_mid;
    drive_ab(up_next(m_ab));
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks += 3;
    if (u_bus.position !== 4'd0) begin errors++; $display("FAIL mid_rst_pos: %0d, expected 0", u_bus.position); end
    if (u_bus.step !== 1'b0)     begin errors++; $display("FAIL mid_rst_step: %0b, expected 0", u_bus.step); end
    if (u_bus.err !== 1'b0)      begin errors++; $display("FAIL mid_rst_err: %0b, expected 0", u_bus.err); end
    sb_q.delete();
    m_pos = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    repeat (WARMUP) @(negedge clk);
    checks += 2;
    if (u_bus.position !== 4'd0) begin errors++; $display("FAIL post_rst_pos: %0d, expected 0", u_bus.position); end
    if (u_bus.err !== 1'b0)      begin errors++; $display("FAIL post_rst_err: %0b, expected 0", u_bus.err); end
  endtask

  initial begin
    u_bus.quad_a  = 1'b1;
    u_bus.quad_b  = 1'b1;
    u_bus.en      = 1'b1;
    u_bus.err_clr = 1'b0;
    m_ab          = 2'b11;
    m_pos         = '0;
    test_reset();
    test_down_wrap();
    test_up_steps();
    test_illegal();
    test_enable();
    test_back_to_back();
`ifdef QUAD_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
